// File: rtl/display_scan_ctrl.sv
// Multiplexed digit scanner: per-slot blanking, dwell timing, masked digits,
// and a shadow frame that only swaps at frame boundaries.
// Ports: clk/rstn, enable, digit_mask, data_in/load/load_ack (frame update),
// sel/digit_en/digit_val (digit drive), frame_done (end-of-frame pulse).
module display_scan_ctrl #(
  parameter int NUM_DIGITS     = 4,
  parameter int DIGIT_W        = 4,
  parameter int TICK_DIV       = 50000,
  parameter int BLANK_CYCLES   = 16,
  parameter bit SEL_ACTIVE_LOW = 1'b1,
  localparam int SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          enable,
  input  logic [NUM_DIGITS-1:0]         digit_mask,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] data_in,
  input  logic                          load,
  output logic                          load_ack,
  output logic [SEL_W-1:0]              sel,
  output logic [NUM_DIGITS-1:0]         digit_en,
  output logic [DIGIT_W-1:0]            digit_val,
  output logic                          frame_done
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [NUM_DIGITS-1:0] EN_OFF =
    {NUM_DIGITS{SEL_ACTIVE_LOW}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_BLANK,
    S_SHOW
  } state_e;

  state_e                             state_q;
  logic [CNT_W-1:0]                   cnt_q;
  logic [SEL_W-1:0]                   sel_q;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] shadow_q;
  logic [DIGIT_W-1:0]                 val_q;
  logic [NUM_DIGITS-1:0]              en_q;
  logic                               ack_q;
  logic                               fd_q;

  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] din_arr;
  logic [SEL_W-1:0]                   lo_sel_d;
  logic [SEL_W-1:0]                   nxt_sel_d;
  logic                               wrap_d;
  logic [NUM_DIGITS-1:0]              en_on;
  logic                               ld_idle;

  assign din_arr = data_in;

  // Downward scan so the lowest set bit is the last one written.
  always_comb begin
    lo_sel_d = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (digit_mask[i]) lo_sel_d = SEL_W'(i);
    end
  end

  // Next digit strictly above sel; no hit means wrap to lowest.
  always_comb begin
    nxt_sel_d = lo_sel_d;
    wrap_d    = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (digit_mask[i] && (SEL_W'(i) > sel_q)) begin
        nxt_sel_d = SEL_W'(i);
        wrap_d    = 1'b0;
      end
    end
  end

  // XOR with the idle pattern gives the polarity-correct one-hot.
  assign en_on   = (NUM_DIGITS'(1) << sel_q) ^ EN_OFF;
  assign ld_idle = load && !ack_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sel_q    <= '0;
      shadow_q <= '0;
      val_q    <= '0;
      en_q     <= EN_OFF;
      ack_q    <= 1'b0;
      fd_q     <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      fd_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          en_q  <= EN_OFF;
          cnt_q <= '0;
          if (ld_idle) begin
            shadow_q <= din_arr;
            ack_q    <= 1'b1;
          end
          if (enable && |digit_mask) begin
            state_q <= S_BLANK;
            sel_q   <= lo_sel_d;
            val_q   <= ld_idle ? din_arr[lo_sel_d]
                               : shadow_q[lo_sel_d];
          end
        end
        S_BLANK: begin
          if (!enable) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            en_q    <= EN_OFF;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == BLANK_LAST) begin
              state_q <= S_SHOW;
              en_q    <= en_on;
            end
          end
        end
        S_SHOW: begin
          if (!enable) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            en_q    <= EN_OFF;
          end else if (cnt_q == SLOT_LAST) begin
            cnt_q <= '0;
            en_q  <= EN_OFF;
            if (!(|digit_mask)) begin
              state_q <= S_IDLE;
            end else begin
              state_q <= S_BLANK;
              sel_q   <= nxt_sel_d;
              if (wrap_d && load) begin
                shadow_q <= din_arr;
                ack_q    <= 1'b1;
                val_q    <= din_arr[nxt_sel_d];
              end else begin
                val_q <= shadow_q[nxt_sel_d];
              end
              fd_q <= wrap_d;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          en_q    <= EN_OFF;
        end
      endcase
    end
  end

  assign load_ack   = ack_q;
  assign sel        = sel_q;
  assign digit_en   = en_q;
  assign digit_val  = val_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: slot table, corner sequences, and random
// stimulus against a slot-level reference model (both polarities).
module tb_display_scan_ctrl;
  localparam int N  = 4;
  localparam int TD = 8;
  localparam int BC = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [3:0]  digit_mask = '0;
  logic [15:0] data_in = '0;

  logic       ack_lo, ack_hi, fd_lo, fd_hi;
  logic [1:0] sel_lo, sel_hi;
  logic [3:0] en_lo, en_hi, val_lo, val_hi;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  display_scan_ctrl #(
    .NUM_DIGITS(N), .DIGIT_W(4), .TICK_DIV(TD),
    .BLANK_CYCLES(BC), .SEL_ACTIVE_LOW(1'b1)
  ) u_lo (
    .clk(clk), .rstn(rstn), .enable(enable),
    .digit_mask(digit_mask), .data_in(data_in),
    .load(load), .load_ack(ack_lo), .sel(sel_lo),
    .digit_en(en_lo), .digit_val(val_lo),
    .frame_done(fd_lo)
  );

  display_scan_ctrl #(
    .NUM_DIGITS(N), .DIGIT_W(4), .TICK_DIV(TD),
    .BLANK_CYCLES(BC), .SEL_ACTIVE_LOW(1'b0)
  ) u_hi (
    .clk(clk), .rstn(rstn), .enable(enable),
    .digit_mask(digit_mask), .data_in(data_in),
    .load(load), .load_ack(ack_hi), .sel(sel_hi),
    .digit_en(en_hi), .digit_val(val_hi),
    .frame_done(fd_hi)
  );

  // Reference: scanning flag, age within slot, current digit, frame copy.
  bit m_scan;
  int m_age;
  int m_cur;
  int m_val;
  int m_sh[N];
  bit m_ack;
  bit m_fd;

  function automatic void model_reset();
    m_scan = 0;
    m_age  = 0;
    m_cur  = 0;
    m_val  = 0;
    m_ack  = 0;
    m_fd   = 0;
    for (int i = 0; i < N; i++) m_sh[i] = 0;
  endfunction

  function automatic void grab_frame();
    for (int i = 0; i < N; i++) m_sh[i] = int'(data_in[4*i +: 4]);
  endfunction

  function automatic void model_step();
    bit pa;
    int k;
    pa    = m_ack;
    m_ack = 0;
    m_fd  = 0;
    if (!rstn) begin
      model_reset();
    end else if (!m_scan) begin
      if (load && !pa) begin
        grab_frame();
        m_ack = 1;
      end
      if (enable && digit_mask != 0) begin
        m_scan = 1;
        m_age  = 0;
        m_cur  = 0;
        while (!digit_mask[m_cur]) m_cur++;
        m_val = m_sh[m_cur];
      end
    end else if (!enable) begin
      m_scan = 0;
      m_age  = 0;
    end else if (m_age < TD - 1) begin
      m_age++;
    end else if (digit_mask == 0) begin
      m_scan = 0;
      m_age  = 0;
    end else begin
      k = 1;
      while (!digit_mask[(m_cur + k) % N]) k++;
      if (m_cur + k >= N) begin
        m_fd = 1;
        if (load) begin
          grab_frame();
          m_ack = 1;
        end
      end
      m_cur = (m_cur + k) % N;
      m_age = 0;
      m_val = m_sh[m_cur];
    end
  endfunction

  // oh is the active-high one-hot; u_lo must show its inverse.
  function automatic logic [23:0] pack(int s, int v, logic [3:0] oh,
                                       bit a, bit f);
    return {2'(s), 2'(s), 4'(v), 4'(v), ~oh, oh, a, a, f, f};
  endfunction

  function automatic logic [23:0] dut_vec();
    return {sel_lo, sel_hi, val_lo, val_hi, en_lo, en_hi,
            ack_lo, ack_hi, fd_lo, fd_hi};
  endfunction

  task automatic check(string name, logic [23:0] exp);
    n_tests++;
    if (dut_vec() !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", name, dut_vec(), exp);
    end
  endtask

  task automatic check_model();
    logic [3:0] oh;
    oh = (m_scan && m_age >= BC) ? 4'(1 << m_cur) : 4'b0;
    check($sformatf("model@%0t", $time),
          pack(m_cur, m_val, oh, m_ack, m_fd));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  typedef struct {
    logic [3:0]  mask;
    bit          ld;
    logic [15:0] din;
    bit          scan;
    int          sel;
    int          val;
    bit          fd;
    bit          ack;
  } rec_t;

  rec_t tbl[$];

  function automatic void add(logic [3:0] mask, bit ld, logic [15:0] din,
                              bit scan, int s, int v, bit fd, bit ack);
    rec_t r;
    r.mask = mask; r.ld = ld; r.din = din; r.scan = scan;
    r.sel = s; r.val = v; r.fd = fd; r.ack = ack;
    tbl.push_back(r);
  endfunction

  initial begin
    logic [3:0] oh;
    int guard;

    add(4'b1111, 0, 16'h0,    1, 0, 1,    0, 0);
    add(4'b1111, 0, 16'h0,    1, 1, 2,    0, 0);
    add(4'b1111, 0, 16'h0,    1, 2, 3,    0, 0);
    add(4'b1111, 0, 16'h0,    1, 3, 4,    0, 0);
    add(4'b1111, 0, 16'h0,    1, 0, 1,    1, 0);
    add(4'b1010, 0, 16'h0,    1, 1, 2,    0, 0);
    add(4'b1010, 0, 16'h0,    1, 3, 4,    0, 0);
    add(4'b1010, 0, 16'h0,    1, 1, 2,    1, 0);
    add(4'b1010, 0, 16'h0,    1, 3, 4,    0, 0);
    add(4'b1010, 0, 16'h0,    1, 1, 2,    1, 0);
    add(4'b1111, 1, 16'hABCD, 1, 2, 3,    0, 0);
    add(4'b1111, 1, 16'hABCD, 1, 3, 4,    0, 0);
    add(4'b1111, 1, 16'hABCD, 1, 0, 'hD, 1, 1);
    add(4'b1111, 0, 16'h0,    1, 1, 'hC, 0, 0);
    add(4'b1111, 0, 16'h0,    1, 2, 'hB, 0, 0);
    add(4'b1111, 0, 16'h0,    1, 3, 'hA, 0, 0);
    add(4'b1111, 0, 16'h0,    1, 0, 'hD, 1, 0);
    add(4'b0100, 0, 16'h0,    1, 2, 'hB, 0, 0);
    add(4'b0100, 0, 16'h0,    1, 2, 'hB, 1, 0);
    add(4'b0100, 0, 16'h0,    1, 2, 'hB, 1, 0);
    add(4'b0000, 0, 16'h0,    0, 2, 'hB, 0, 0);

    model_reset();
    tick();
    tick();
    check("reset", pack(0, 0, 4'b0, 0, 0));
    rstn = 1'b1;

    load    = 1'b1;
    data_in = 16'h4321;
    tick();
    check("idle_ack", pack(0, 0, 4'b0, 1, 0));
    load = 1'b0;
    tick();
    check("idle_ack_end", pack(0, 0, 4'b0, 0, 0));

    foreach (tbl[r]) begin
      enable     = 1'b1;
      digit_mask = tbl[r].mask;
      load       = tbl[r].ld;
      if (tbl[r].ld) data_in = tbl[r].din;
      for (int c = 0; c < TD; c++) begin
        tick();
        oh = (tbl[r].scan && c >= BC) ? 4'(1 << tbl[r].sel) : 4'b0;
        check($sformatf("tbl%0d.c%0d", r, c),
              pack(tbl[r].sel, tbl[r].val, oh,
                   tbl[r].ack && c == 0, tbl[r].fd && c == 0));
      end
    end
    load = 1'b0;

    // Drop enable in the middle of digit 2's show window.
    digit_mask = 4'b1111;
    guard = 0;
    do begin
      tick();
      guard++;
    end while (!(sel_lo == 2'd2 && en_lo == 4'b1011) && guard < 64);
    n_tests++;
    if (guard >= 64) begin
      n_fail++;
      $display("FAIL wait_sel2 got=timeout want=sel2_show");
    end
    tick();
    tick();
    enable = 1'b0;
    tick();
    check("drop", pack(2, 'hB, 4'b0, 0, 0));
    tick();
    check("drop_hold", pack(2, 'hB, 4'b0, 0, 0));
    enable = 1'b1;
    tick();
    check("reen_blank0", pack(0, 'hD, 4'b0, 0, 0));
    tick();
    check("reen_blank1", pack(0, 'hD, 4'b0, 0, 0));
    tick();
    check("reen_show", pack(0, 'hD, 4'b0001, 0, 0));

    // Asynchronous reset between clock edges during show.
    guard = 0;
    do begin
      tick();
      guard++;
    end while (en_hi == 4'b0 && guard < 64);
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    check("async_rst", pack(0, 0, 4'b0, 0, 0));
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 1500; i++) begin
      enable = ($urandom_range(0, 99) < 95);
      if ($urandom_range(0, 15) == 0)
        digit_mask = ($urandom_range(0, 7) == 0)
                     ? 4'b0 : 4'($urandom_range(1, 15));
      if (!load && $urandom_range(0, 19) == 0) begin
        load    = 1'b1;
        data_in = 16'($urandom);
      end
      tick();
      if (load && ack_lo) load = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Time-multiplexed scan controller for a shared multi-digit display bus (one common segment/value bus, N digit-select lines).
- Sequences digit slots with a programmable dwell time and a dead-time blanking interval to prevent ghosting, and skips masked-off digits.
- Double-buffers the display frame so new data is applied only at frame boundaries.
- Sits between the value-producing logic and the segment decoder and digit drivers.

Parameters:
- NUM_DIGITS, 4, number of digit slots (2..8).
- DIGIT_W, 4, bits per digit value.
- TICK_DIV, 50000, clocks per digit slot, blank plus show; must be >= BLANK_CYCLES+1.
- BLANK_CYCLES, 16, clocks all digits are off at the start of each slot; must be >= 1.
- SEL_ACTIVE_LOW, 1, 1 = digit_en active-low; 0 = active-high.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- enable  in  1  scan enable (level).
- digit_mask  in  NUM_DIGITS  bit i = 1 means digit i is scanned.
- data_in  in  NUM_DIGITS*DIGIT_W  frame data; digit i occupies bits [i*DIGIT_W +: DIGIT_W].
- load  in  1  frame load request; hold high with data_in stable until load_ack.
- load_ack  out  1  one-cycle pulse; shadow frame captured from data_in on this cycle.
- sel  out  clog2(NUM_DIGITS) (min 1)  index of the current digit.
- digit_en  out  NUM_DIGITS  one-hot digit drive, polarity set by SEL_ACTIVE_LOW.
- digit_val  out  DIGIT_W  value of the current digit, taken from the shadow frame.
- frame_done  out  1  one-cycle pulse at the end of each scanned frame.

Behaviour:
- Reset (async, rstn=0):
  - State IDLE; sel=0; digit_val=0; shadow frame=0.
  - Slot counter=0; load_ack=0; frame_done=0.
  - digit_en all inactive (all 1s if SEL_ACTIVE_LOW, else all 0s).
- State IDLE:
  - digit_en inactive.
  - If load=1, capture shadow from data_in and pulse load_ack the following cycle.
  - On a clk edge with enable=1 and digit_mask!=0: go to BLANK, with sel = lowest set bit of digit_mask.
- State BLANK (BLANK_CYCLES clocks):
  - digit_en inactive.
  - digit_val = shadow[sel], updated on entry to BLANK.
  - Then go to SHOW.
- State SHOW (TICK_DIV-BLANK_CYCLES clocks):
  - digit_en asserts only bit sel.
  - On the last SHOW clock, choose next sel = next set bit of digit_mask strictly above sel, wrapping to the lowest set bit.
  - If the chosen index <= current sel, this is a frame boundary.
  - Then go to BLANK.
- Slot period is exactly TICK_DIV clocks. Every scanned digit gets an identical show time.
- Frame boundary:
  - frame_done pulses for one clock, coincident with BLANK entry.
  - If load=1 at that edge, shadow <= data_in and load_ack pulses on the same cycle as frame_done.
  - The new slot's digit_val comes from the new shadow.
  - load outside a boundary (while scanning) is held off; no ack is issued.
- digit_mask is sampled only when choosing the next sel.
  - Mid-slot mask changes do not affect the current slot.
  - Mask==0 at selection: go to IDLE, digits off, no frame_done.
- Single enabled digit: every slot is a frame boundary, so frame_done pulses every TICK_DIV clocks.
- enable deasserted in BLANK or SHOW:
  - Next edge goes to IDLE with digit_en inactive immediately.
  - Counter is cleared, sel holds, no frame_done.
  - Re-enable restarts from the lowest set bit.
- Simultaneous events: an enable drop takes priority over a frame boundary, so neither load_ack nor frame_done is issued.
- Reset mid-slot: all outputs return to reset values asynchronously.
- digit_en is never asserted on more than one bit, and never during BLANK or IDLE.

Test Plan (NUM_DIGITS=4, DIGIT_W=4, TICK_DIV=8, BLANK_CYCLES=2, SEL_ACTIVE_LOW=1 unless noted):
- Reset, then enable=1, mask=4'b1111, preloaded frame 0x4321 -> sel 0,1,2,3,0 with slots of 8 clocks. digit_en=4'b1111 for 2 clocks, then 4'b1110 for 6 clocks, and so on. digit_val=1,2,3,4. frame_done pulses every 32 clocks.
- mask=4'b1010 -> sel alternates 1,3. frame_done every 16 clocks. Digits 0 and 2 never asserted.
- Mid-frame, load=1 with data_in=0xABCD -> load_ack and frame_done pulse together at the next wrap. The next slot shows digit_val=0xD; the frame in progress still shows old values.
- enable dropped in mid-SHOW of digit 2 -> digit_en=4'b1111 next clock, state IDLE. Re-enable restarts at sel=0 with BLANK first.
- mask changed to 4'b0000 mid-slot -> the current slot completes, then IDLE with no frame_done. mask=4'b0100 -> frame_done every 8 clocks.
- SEL_ACTIVE_LOW=0, and rstn asserted mid-SHOW -> digit_en=0, digit_val=0, sel=0 immediately, without a clock edge.
